// File: rtl/uart_pkg.sv
// Shared UART settings: baud and stop-bit defaults plus the transmit FSM state encoding.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 868;
    localparam int unsigned STOP_BITS_DEF    = 1;
    localparam int unsigned BYTE_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the final cycle of each bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    localparam int unsigned CNT_W       = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             bit_end_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_end_q, bit_end_d;

    // bit_end is registered alongside the count so it always equals (cnt == last)
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
        bit_end_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_end_q <= bit_end_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign bit_end_o = bit_end_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-drain UART transmitter: pops bytes from a 1-cycle-latency FIFO and sends 8N1/8N2 frames.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned STOP_BITS    = STOP_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic [BYTE_W-1:0] fifo_data_i,
    output logic              tx_serial_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned      CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]       LAST_DATA    = 3'(BYTE_W - 1);
    localparam logic [2:0]       LAST_STOP    = 3'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [2:0]        idx_q, idx_d;
    logic              tx_q, tx_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  cnt;
    logic              bit_end;
    logic              baud_clr;

    assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (baud_clr),
        .cnt_o     (cnt),
        .bit_end_o (bit_end)
    );

    // Outputs are decoded from the next state so the registered pins track state_q exactly
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        rd_en_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rd_en_q) begin
                    state_d = ST_LOAD;
                end else if (tx_en_i && !fifo_empty_i) begin
                    rd_en_d = 1'b1;
                end
            end
            ST_LOAD: begin
                shreg_d = fifo_data_i;
                idx_d   = '0;
                state_d = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[BYTE_W-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if ((idx_q == LAST_STOP) && (cnt == CNT_PRE_LAST)) begin
                    done_d = 1'b1;
                end
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                        // Pop in the first idle cycle so only IDLE+LOAD separate frames
                        if (tx_en_i && !fifo_empty_i) begin
                            rd_en_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_d   = 1'b1;
        if (state_d == ST_START) begin
            tx_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            tx_d = shreg_d[0];
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd_en_o = rd_en_q;
    assign tx_serial_o  = tx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFOs feed two builds (1 and 2 stop bits); a frame monitor scores bytes.
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b1;

    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       rd_en, tx, busy, done;
    logic [7:0] fq[$];

    logic       fifo_empty_b = 1'b1;
    logic [7:0] fifo_data_b = 8'h00;
    logic       rd_en_b, tx_b, busy_b, done_b;
    logic [7:0] fq_b[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_en_i(tx_en), .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(rd_en), .fifo_data_i(fifo_data), .tx_serial_o(tx),
        .busy_o(busy), .done_o(done)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_en_i(1'b1), .fifo_empty_i(fifo_empty_b),
        .fifo_rd_en_o(rd_en_b), .fifo_data_i(fifo_data_b), .tx_serial_o(tx_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sync_fifo read ports: data one cycle after rd_en, empty updated on the clock
    always @(posedge clk) begin
        if (rd_en && fq.size() != 0) fifo_data <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
        if (rd_en_b && fq_b.size() != 0) fifo_data_b <= fq_b.pop_front();
        fifo_empty_b <= (fq_b.size() == 0);
    end

    always @(negedge clk) begin
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timed out", nm);
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while (n < budget && !(fq.size() == 0 && fifo_empty && !busy && !rd_en)) begin
            tick();
            n++;
        end
        if (n >= budget) fail_now(nm);
        repeat (3) tick();
    endtask

    task automatic wait_fall(input string nm, input bit use_b, input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            tick();
            if ((use_b ? tx_b : tx) == 1'b0) ok = 1'b1;
            n++;
        end
        if (!ok) fail_now(nm);
    endtask

    // Monitor: capture each frame cycle by cycle and compare with the next expected byte
    initial begin
        logic [63:0] ol, od, el, ed;
        logic [7:0]  b;
        bit          abort;
        forever begin
            @(negedge clk);
            if (rd_en) chk("no_underflow_pop", 64'(fifo_empty), 64'd0);
            if (!rst && tx == 1'b0) begin
                starts.push_back(cyc);
                b = 8'h00;
                if (exp_q.size() == 0) chk("unexpected_frame", 64'(exp_q.size()), 64'd1);
                else b = exp_q.pop_front();
                abort = 1'b0;
                ol = '0;
                od = '0;
                for (int k = 0; k < 40; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                    ol[k] = tx;
                    od[k] = done;
                end
                el = '0;
                for (int k = 0; k < 40; k++) begin
                    if (k < 4) el[k] = 1'b0;
                    else if (k < 36) el[k] = b[(k - 4) / 4];
                    else el[k] = 1'b1;
                end
                ed = 64'd1 << 39;
                if (!abort) begin
                    chk($sformatf("frame_line_%02h", b), ol, el);
                    chk($sformatf("frame_done_%02h", b), od, ed);
                end
            end
        end
    end

    initial begin
        int bad, r0, d0, s0;
        bit ok;
        logic [63:0] ol, od, el, ed;

        rst = 1'b1;
        tx_en = 1'b1;
        repeat (3) tick();
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        // 1: empty FIFO with tx enabled stays idle
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("idle_bad_cycles", 64'(bad), 64'd0);

        // 2: single byte
        r0 = rd_cnt; d0 = done_cnt;
        push(8'h65);
        wait_drain("t2_drain", 200);
        chk("t2_rd_pulses", 64'(rd_cnt - r0), 64'd1);
        chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);

        // 3: back-to-back frames, two idle-high cycles between them
        r0 = rd_cnt; s0 = starts.size();
        push(8'h65); push(8'h66); push(8'h00);
        wait_drain("t3_drain", 400);
        chk("t3_rd_pulses", 64'(rd_cnt - r0), 64'd3);
        chk("t3_frames", 64'(starts.size() - s0), 64'd3);
        if (starts.size() >= s0 + 3) begin
            chk("t3_gap_1", 64'(starts[s0+1] - starts[s0]), 64'd42);
            chk("t3_gap_2", 64'(starts[s0+2] - starts[s0+1]), 64'd42);
        end
        chk("t3_fifo_empty", 64'(fifo_empty), 64'd1);

        // 4: tx_en dropped mid-frame finishes the frame, then holds off the next pop
        r0 = rd_cnt;
        push(8'h66); push(8'h41);
        wait_fall("t4_start", 1'b0, 100, ok);
        repeat (12) tick();
        tx_en = 1'b0;
        repeat (100) tick();
        chk("t4_rd_held", 64'(rd_cnt - r0), 64'd1);
        chk("t4_fifo_left", 64'(fq.size()), 64'd1);
        chk("t4_line_idle", 64'(tx), 64'd1);
        chk("t4_busy_idle", 64'(busy), 64'd0);
        tx_en = 1'b1;
        wait_drain("t4_drain", 200);
        chk("t4_rd_total", 64'(rd_cnt - r0), 64'd2);

        // 5: reset during data bit 3 aborts the frame; the next byte follows cleanly
        r0 = rd_cnt; d0 = done_cnt;
        push(8'h5A); push(8'h3C);
        wait_fall("t5_start", 1'b0, 100, ok);
        repeat (17) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_line", 64'(tx), 64'd1);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_done", 64'(done), 64'd0);
        wait_drain("t5_drain", 200);
        chk("t5_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t5_rd_pulses", 64'(rd_cnt - r0), 64'd2);

        // 6: two stop bits
        fq_b.push_back(8'hFF);
        wait_fall("t6_start", 1'b1, 100, ok);
        ol = '0; od = '0;
        for (int k = 0; k < 44; k++) begin
            if (k > 0) tick();
            ol[k] = tx_b;
            od[k] = done_b;
        end
        el = '0;
        for (int k = 4; k < 44; k++) el[k] = 1'b1;
        ed = 64'd1 << 43;
        chk("t6_line", ol, el);
        chk("t6_done", od, ed);

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
